// File: rtl/hazard_scheduler.sv
// hazard_scheduler: ID-stage sequencing against in-flight writers.
// Tracks destination registers held by the post-ID stages, raises a RAW stall
// (hazard), a branch flush and a memory freeze, and keeps saturating stall counters.
// Optional feature macro: HAZARD_FORWARDING_EN (only load-use on EXE stalls).
module hazard_scheduler #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic [3:0]       id_dest,
   input  logic             exe_branch_taken,
   input  logic             mem_ready,
   output logic             hazard,
   output logic             flush,
   output logic             freeze_all,
   output logic [CNT_W-1:0] hazard_cycles,
   output logic [CNT_W-1:0] mem_stall_cycles
);

   typedef struct packed {
      logic       valid;
      logic [3:0] dest;
      logic       load;
   } sb_entry_t;

   // Entry 0 is EXE; the oldest entry falls off as its write reaches the register file.
   sb_entry_t        sb_q [DEPTH];
   sb_entry_t        sb_d [DEPTH];
   logic [CNT_W-1:0] hz_cnt_q, hz_cnt_d;
   logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
   logic             src1_hit;
   logic             src2_hit;
   logic             issue;

   // Register-address matches against the in-flight writers.
   always_comb begin
      src1_hit = 1'b0;
      src2_hit = 1'b0;
`ifdef HAZARD_FORWARDING_EN
      // Forwarding covers everything except a load whose data is not back yet.
      src1_hit = sb_q[0].valid & sb_q[0].load & (sb_q[0].dest == src1);
      src2_hit = sb_q[0].valid & sb_q[0].load & (sb_q[0].dest == src2);
`else
      for (int i = 0; i < DEPTH; i++) begin
         src1_hit = src1_hit | (sb_q[i].valid & (sb_q[i].dest == src1));
         src2_hit = src2_hit | (sb_q[i].valid & (sb_q[i].dest == src2));
      end
`endif
   end

   // Control outputs; reset silences all, a memory freeze silences flush and hazard.
   assign freeze_all = ~rst & ~mem_ready;
   assign flush      = ~rst & mem_ready & exe_branch_taken;
   assign hazard     = ~rst & mem_ready & ~flush & id_valid &
                       (src1_hit | (two_src & src2_hit));
   assign issue      = id_valid & id_wb_en & ~hazard & ~flush;

   // Next scoreboard and counter values; everything holds during a memory freeze.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         sb_d[i] = sb_q[i];
      end
      if (mem_ready) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            sb_d[i] = sb_q[i-1];
         end
         sb_d[0] = issue ? sb_entry_t'{valid: 1'b1, dest: id_dest, load: id_mem_r_en}
                         : sb_entry_t'('0);
      end
      hz_cnt_d = hz_cnt_q;
      if (hazard && (hz_cnt_q != {CNT_W{1'b1}})) begin
         hz_cnt_d = hz_cnt_q + CNT_W'(1);
      end
      ms_cnt_d = ms_cnt_q;
      if (!mem_ready && (ms_cnt_q != {CNT_W{1'b1}})) begin
         ms_cnt_d = ms_cnt_q + CNT_W'(1);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            sb_q[i] <= '0;
         end
         hz_cnt_q <= '0;
         ms_cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            sb_q[i] <= sb_d[i];
         end
         hz_cnt_q <= hz_cnt_d;
         ms_cnt_q <= ms_cnt_d;
      end
   end

   assign hazard_cycles    = hz_cnt_q;
   assign mem_stall_cycles = ms_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: directed and random stimulus with an expected-output queue.
module tb_hazard_scheduler;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic             id_valid, two_src, id_wb_en, id_mem_r_en;
  logic [3:0]       src1, src2, id_dest;
  logic             exe_branch_taken, mem_ready;
  logic             hazard, flush, freeze_all;
  logic [CNT_W-1:0] hazard_cycles, mem_stall_cycles;

  hazard_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .src1(src1), .src2(src2), .two_src(two_src),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .exe_branch_taken(exe_branch_taken), .mem_ready(mem_ready),
    .hazard(hazard), .flush(flush), .freeze_all(freeze_all),
    .hazard_cycles(hazard_cycles), .mem_stall_cycles(mem_stall_cycles)
  );

  // scoreboard: expected {hazard, flush, freeze_all} per driven cycle
  logic [2:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic set_id(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic wb, input logic ld, input logic [3:0] d);
    id_valid = v; src1 = s1; src2 = s2; two_src = two;
    id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
  endtask

  task automatic set_ctl(input logic br, input logic mr);
    exe_branch_taken = br; mem_ready = mr;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    set_ctl(1'b0, 1'b1);
  endtask

  // Inputs are already driven; record expectation, compare mid-cycle, advance.
  task automatic step(input string tag, input logic [2:0] exp);
    logic [2:0] want;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    check_eq(tag, {29'd0, hazard, flush, freeze_all}, {29'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    step(tag, 3'b000);
    rst = 1'b0;
  endtask

  task automatic drain();
    idle();
    step("drain0", 3'b000);
    step("drain1", 3'b000);
  endtask

  initial begin
    logic br, mr;
    int   exp_ms;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // reset forces outputs low even with branch pending and memory busy
    set_ctl(1'b1, 1'b0);
    do_reset("reset_outputs");
    check_eq("reset_hz_cnt", 32'(hazard_cycles), 32'd0);
    check_eq("reset_ms_cnt", 32'(mem_stall_cycles), 32'd0);
    idle();

    // writer r3 then reader of r3
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd3);
    step("wr_r3", 3'b000);
    set_id(1'b1, 4'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd4);
    step("raw_c1", FWD ? 3'b000 : 3'b100);
    step("raw_c2", FWD ? 3'b000 : 3'b100);
    step("raw_c3", 3'b000);
    check_eq("raw_hz_cnt", 32'(hazard_cycles), FWD ? 32'd0 : 32'd2);
    drain();

    // two_src gating on src2
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5);
    step("wr_r5a", 3'b000);
    set_id(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0);
    step("src2_unused", 3'b000);
    drain();
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd5);
    step("wr_r5b", 3'b000);
    set_id(1'b1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0, 4'd0);
    step("src2_used", FWD ? 3'b000 : 3'b100);
    drain();

    // memory stall with a pending load-use match
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7);
    step("ld_r7", 3'b000);
    set_id(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    set_ctl(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("memstall", 3'b001);
    set_ctl(1'b0, 1'b1);
    step("after_stall_c1", 3'b100);
    step("after_stall_c2", FWD ? 3'b000 : 3'b100);
    step("after_stall_c3", 3'b000);
    check_eq("ms_cnt_4", 32'(mem_stall_cycles), 32'd4);
    drain();

    // branch deferred by memory stall, then flush beats hazard
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd9);
    step("ld_r9", 3'b000);
    set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    set_ctl(1'b1, 1'b0);
    step("br_deferred", 3'b001);
    set_id(1'b1, 4'd9, 4'd0, 1'b0, 1'b1, 1'b1, 4'd11);
    set_ctl(1'b1, 1'b1);
    step("br_flush", 3'b010);
    set_id(1'b1, 4'd11, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    set_ctl(1'b0, 1'b1);
    step("flushed_bubble", 3'b000);
    drain();

    // reset in the middle of a stall
    set_id(1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd4);
    step("ld_r4", 3'b000);
    set_id(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    step("pre_rst_hz", 3'b100);
    do_reset("rst_mid_stall");
    step("post_rst_hz", 3'b000);
    check_eq("post_rst_hz_cnt", 32'(hazard_cycles), 32'd0);
    check_eq("post_rst_ms_cnt", 32'(mem_stall_cycles), 32'd0);

    // hazard counter saturation: self-dependent load every cycle
    idle();
    do_reset("rst_sat");
    set_id(1'b1, 4'd6, 4'd0, 1'b0, 1'b1, 1'b1, 4'd6);
    for (int i = 0; i < 30; i++) begin
      step("self_dep", (FWD ? (i % 2 == 1) : (i % 3 != 0)) ? 3'b100 : 3'b000);
    end
    check_eq("hz_cnt_sat", 32'(hazard_cycles), 32'd15);

    // random branch / memory-ready traffic with no ID instructions
    idle();
    do_reset("rst_rand");
    exp_ms = 0;
    for (int i = 0; i < 24; i++) begin
      br = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      set_id(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'b1, 1'b0, 1'b0, 4'd0);
      set_ctl(br, mr);
      step("rand", {1'b0, br & mr, ~mr});
      if (!mr && exp_ms < 15) exp_ms++;
    end
    check_eq("ms_cnt_rand", 32'(mem_stall_cycles), 32'(exp_ms));
    idle();
    set_ctl(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step("ms_fill", 3'b001);
    check_eq("ms_cnt_sat", 32'(mem_stall_cycles), 32'd15);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
